// File: rtl/phy_mgmt_ctrl.sv
// PHY reset sequencer and Clause-22 MDIO master for the board Ethernet PHYs.
// Optional: define PHY_MGMT_PREAMBLE_SUPPRESS_EN to drop the 32-bit preamble.
module phy_mgmt_ctrl #(
    parameter int NUM_PHY         = 4,
    parameter int CLK_DIV         = 50,
    parameter int RST_CYCLES      = 1000000,
    parameter int POST_RST_CYCLES = 500000
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    input  logic               soft_reset,
    output logic [NUM_PHY-1:0] phy_rstn,
    output logic               mdc,
    input  logic               mdio_i,
    output logic               mdio_o,
    output logic               mdio_t,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [4:0]         cmd_phy_addr,
    input  logic [4:0]         cmd_reg_addr,
    input  logic [15:0]        cmd_wdata,
    output logic               rsp_valid,
    output logic [15:0]        rsp_rdata,
    output logic               rsp_error,
    output logic               init_done
);

    typedef enum logic [2:0] {
        ST_RST_HOLD, ST_RST_WAIT, ST_IDLE, ST_XFER, ST_DONE
    } state_t;

`ifdef PHY_MGMT_PREAMBLE_SUPPRESS_EN
    localparam int NBITS = 32;
`else
    localparam int NBITS = 64;
`endif
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_cnt;
    logic [DIV_W-1:0]  r_div;
    logic              r_phase;
    logic [6:0]        r_bit;
    logic [63:0]       r_frame;
    logic              r_write;
    logic [15:0]       r_rx;
    logic              r_ta_err;
    logic [15:0]       r_rdata;
    logic              r_error;

    logic              w_accept;
    logic              w_div_end;
    logic              w_sample;
    logic              w_bit_end;
    logic [31:0]       w_frame32;

    assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
    assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_sample  = (r_state == ST_XFER) && w_div_end && !r_phase;
    assign w_bit_end = (r_state == ST_XFER) && w_div_end && r_phase;

    // Released fields of a read frame are filled with ones; mdio_t masks them anyway.
    assign w_frame32 = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                        (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_state <= ST_RST_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (soft_reset) begin
            w_state_next = ST_RST_HOLD;
        end else begin
            case (r_state)
                ST_RST_HOLD: if (r_cnt == 32'(RST_CYCLES - 1))      w_state_next = ST_RST_WAIT;
                ST_RST_WAIT: if (r_cnt == 32'(POST_RST_CYCLES - 1)) w_state_next = ST_IDLE;
                ST_IDLE:     if (cmd_valid)                          w_state_next = ST_XFER;
                ST_XFER:     if (w_bit_end && r_bit == 7'(NBITS - 1)) w_state_next = ST_DONE;
                ST_DONE:     w_state_next = ST_IDLE;
                default:     w_state_next = ST_RST_HOLD;
            endcase
        end
    end

    always_comb begin
        phy_rstn  = '1;
        mdc       = 1'b0;
        mdio_o    = 1'b1;
        mdio_t    = 1'b1;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        init_done = 1'b1;
        case (r_state)
            ST_RST_HOLD: begin
                phy_rstn  = '0;
                init_done = 1'b0;
            end
            ST_RST_WAIT: init_done = 1'b0;
            ST_IDLE:     cmd_ready = 1'b1;
            ST_XFER: begin
                mdc    = r_phase;
                mdio_o = r_frame[63];
                // Reads hand the bus to the PHY from the first turnaround bit.
                mdio_t = r_write ? 1'b0 : (r_bit >= 7'(NBITS - 18));
            end
            ST_DONE:     rsp_valid = 1'b1;
            default:     init_done = 1'b0;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_cnt    <= '0;
            r_div    <= '0;
            r_phase  <= 1'b0;
            r_bit    <= '0;
            r_frame  <= '0;
            r_write  <= 1'b0;
            r_rx     <= '0;
            r_ta_err <= 1'b0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (soft_reset || w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_RST_HOLD || r_state == ST_RST_WAIT) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_accept && !soft_reset) begin
`ifdef PHY_MGMT_PREAMBLE_SUPPRESS_EN
                r_frame <= {w_frame32, 32'h0};
`else
                r_frame <= {32'hFFFF_FFFF, w_frame32};
`endif
                r_write  <= cmd_write;
                r_div    <= '0;
                r_phase  <= 1'b0;
                r_bit    <= '0;
                r_rx     <= '0;
                r_ta_err <= 1'b0;
            end else if (r_state == ST_XFER) begin
                if (w_div_end) begin
                    r_div   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
                if (w_sample) begin
                    r_rx <= {r_rx[14:0], mdio_i};
                    if (r_bit == 7'(NBITS - 17)) r_ta_err <= mdio_i;
                end
                if (w_bit_end) begin
                    r_frame <= {r_frame[62:0], 1'b1};
                    r_bit   <= r_bit + 7'd1;
                end
            end

            if (r_state == ST_XFER && w_state_next == ST_DONE) begin
                r_rdata <= r_write ? 16'h0 : r_rx;
                r_error <= !r_write && r_ta_err;
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

endmodule

// File: doc/phy_mgmt_ctrl.md
Name: phy_mgmt_ctrl

Overview:
Sequences the four board Ethernet PHYs and arbitrates access to the shared MDIO management bus. After reset it holds phy_rstn low, releases it, waits for PHY settling, then accepts single MDIO read/write commands from the register/host side. Each command is serialised as a Clause-22 frame on mdc/mdio. It sits beside the RGMII MACs in the top level and drives the mdc, mdio and phy_rstn_1..4 pins.

Parameters:
NUM_PHY, 4, number of phy_rstn outputs
CLK_DIV, 50, axi_aclk cycles per MDC half-period; minimum 2
RST_CYCLES, 1000000, cycles phy_rstn is held low
POST_RST_CYCLES, 500000, cycles waited after release before init_done

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  synchronous, active-low reset
soft_reset  in  1  one-cycle pulse; re-runs the PHY reset sequence
phy_rstn  out  NUM_PHY  PHY resets, active low
mdc  out  1  MDIO clock
mdio_i  in  1  MDIO input from pad buffer
mdio_o  out  1  MDIO output to pad buffer
mdio_t  out  1  tristate control; 1 = released/input
cmd_valid  in  1  command request
cmd_ready  out  1  command accept
cmd_write  in  1  1 = write, 0 = read
cmd_phy_addr  in  5  PHYAD
cmd_reg_addr  in  5  REGAD
cmd_wdata  in  16  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  16  read data; 0 for writes
rsp_error  out  1  read turnaround bit was not 0
init_done  out  1  reset sequence complete

Behaviour:
- Reset values (axi_aresetn=0 at a rising edge): phy_rstn=0, mdc=0, mdio_o=1, mdio_t=1, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, init_done=0, FSM=RST_HOLD, counters cleared.
- RST_HOLD:
  - phy_rstn all 0 for RST_CYCLES cycles.
  - Then go to RST_WAIT.
- RST_WAIT:
  - phy_rstn all 1 for POST_RST_CYCLES cycles.
  - Then go to IDLE and set init_done=1; init_done stays 1 until the next soft_reset or reset.
- IDLE:
  - cmd_ready=1, mdc=0, mdio_t=1.
  - When cmd_valid && cmd_ready: capture all cmd_* fields, cmd_ready=0 from the next cycle, go to XFER.
  - cmd_valid outside IDLE is ignored; the requester must hold it.
- XFER:
  - 64 bit periods: 32 preamble ones, then ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]. All fields MSB first.
  - Each bit period is 2*CLK_DIV cycles: mdc=0 for the first CLK_DIV cycles, mdc=1 for the second.
  - mdio_o updates on the cycle mdc falls (start of the bit period). mdio_i is sampled on the cycle mdc rises.
  - Write: mdio_t=0 for all 64 bits; TA is driven as 10.
  - Read:
    - mdio_t=0 through preamble and the first 14 frame bits; mdio_t=1 from TA onward.
    - Second TA sample != 0 sets rsp_error.
    - 16 data samples shift into rsp_rdata regardless of error.
- DONE:
  - One cycle with rsp_valid=1, mdc=0, mdio_t=1, cmd_ready=0.
  - Next state is IDLE.
  - rsp_rdata and rsp_error hold until the next DONE.
- Latency: accept -> rsp_valid = 1 + 64*2*CLK_DIV cycles.
- soft_reset:
  - In any state, the next cycle enters RST_HOLD with its counter cleared and init_done=0.
  - An in-flight XFER is aborted with no rsp_valid; mdio_t=1 and mdc=0 immediately.
  - soft_reset during RST_HOLD restarts the hold count.
- If soft_reset and a command accept occur in the same cycle, soft_reset wins and the command is dropped.
- Only one transaction is outstanding at a time; there is no queueing.

Optional Feature:
PHY_MGMT_PREAMBLE_SUPPRESS_EN:
- Defined: the 32-bit preamble is omitted, XFER is 32 bit periods, and latency is 1 + 32*2*CLK_DIV cycles.
- Undefined: the full 32-bit preamble is sent as above.

Test Plan:
Common setup: CLK_DIV=2, RST_CYCLES=20, POST_RST_CYCLES=10, macro undefined unless stated.
1. Release axi_aresetn -> phy_rstn=4'h0 for 20 cycles, then 4'hF; init_done=1 and cmd_ready=1 exactly 10 cycles later.
2. Write phy 1, reg 0x00, data 0x1140 -> mdio_o bits at mdc rise: 32x1, 01 01 00001 00000 10 0001000101000000; mdio_t=0 throughout; rsp_valid 257 cycles after accept; rsp_error=0, rsp_rdata=0.
3. Read phy 2, reg 0x02; PHY model drives TA=z0 and data 0x0141 -> mdio_t=1 from frame bit 14; rsp_rdata=0x0141, rsp_error=0.
4. Read with mdio_i tied 1 (no PHY) -> rsp_error=1, rsp_rdata=0xFFFF.
5. soft_reset pulse at bit period 40 of a write -> no rsp_valid; mdio_t=1 next cycle; phy_rstn=0 for 20 cycles; init_done falls, then re-rises 30 cycles after the pulse.
6. PHY_MGMT_PREAMBLE_SUPPRESS_EN defined, write as in 2 -> frame starts with 01 immediately; rsp_valid 129 cycles after accept.
